// File: rtl/caliptra_imem_ldr_pkg.sv
// Shared types for the ICCM boot image loader: session states and buffered write entries.
package caliptra_imem_ldr_pkg;

  localparam int unsigned LDR_ADDR_W = 13;
  localparam int unsigned LDR_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ldr_state_e;

  typedef struct packed {
    logic [LDR_ADDR_W-1:0] addr;
    logic [LDR_DATA_W-1:0] data;
  } ldr_entry_t;

endpackage

// File: rtl/caliptra_imem_ldr_fifo.sv
// In-order write buffer for loader beats; exposes every slot address and its valid bit
// so the arbiter can detect core reads of not-yet-written words.
module caliptra_imem_ldr_fifo
  import caliptra_imem_ldr_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  ldr_entry_t                            push_data,
  input  logic                                  pop,
  output ldr_entry_t                            head,
  output logic                                  full,
  output logic                                  empty,
  output logic [$clog2(DEPTH):0]                level,
  output logic [DEPTH-1:0][LDR_ADDR_W-1:0]      entry_addr,
  output logic [DEPTH-1:0]                      entry_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [PTR_W:0]          wr_ptr;
  logic [PTR_W:0]          rd_ptr;
  ldr_entry_t [DEPTH-1:0]  mem;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LVL_W'(1);
      if (pop)  rd_ptr <= rd_ptr + LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == LVL_W'(DEPTH));
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // A slot is live when its distance from the read pointer is below the fill level.
  always_comb begin
    entry_valid = '0;
    entry_addr  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_addr[i]  = mem[i].addr;
      entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr[PTR_W-1:0]} < level);
    end
  end

endmodule

// File: rtl/caliptra_imem_load_arbiter.sv
// Shares the single ICCM SRAM port between core fetch (always wins) and the external image
// loader, whose writes are buffered and drained on core-idle cycles; tracks the load session.
module caliptra_imem_load_arbiter
  import caliptra_imem_ldr_pkg::*;
#(
  parameter int unsigned ADDR_W     = LDR_ADDR_W,
  parameter int unsigned DATA_W     = LDR_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic [ADDR_W:0]               load_words,
  input  logic                          ext_valid,
  output logic                          ext_ready,
  input  logic [ADDR_W-1:0]             ext_addr,
  input  logic [DATA_W-1:0]             ext_wdata,
  input  logic                          core_cs,
  input  logic [ADDR_W-1:0]             core_addr,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          sram_cs,
  output logic                          sram_we,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  input  logic [DATA_W-1:0]             sram_rdata,
  output logic                          load_busy,
  output logic                          load_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          raw_hazard
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  ldr_state_e                           state;
  ldr_state_e                           state_nxt;
  logic [CNT_W-1:0]                     word_cnt;
  logic [CNT_W-1:0]                     word_target;
  logic                                 start_ok;
  logic                                 last_beat;
  logic                                 accept;
  logic                                 wr_issue;
  logic                                 hazard_hit;
  logic                                 fifo_full;
  logic                                 fifo_empty;
  ldr_entry_t                           push_entry;
  ldr_entry_t                           head;
  logic [FIFO_DEPTH-1:0][LDR_ADDR_W-1:0] entry_addr;
  logic [FIFO_DEPTH-1:0]                entry_valid;

  assign push_entry = '{addr: LDR_ADDR_W'(ext_addr), data: LDR_DATA_W'(ext_wdata)};
  assign accept     = ext_valid & ext_ready;
  assign last_beat  = ((word_cnt + CNT_W'(1)) == word_target);

  // Core owns the port whenever it asks; rst blocks any write of stale buffered data.
  assign wr_issue   = ~rst & ~core_cs & ~fifo_empty;
  assign sram_cs    = core_cs | wr_issue;
  assign sram_we    = wr_issue;
  assign sram_addr  = core_cs ? core_addr : ADDR_W'(head.addr);
  assign sram_wdata = DATA_W'(head.data);
  assign core_rdata = sram_rdata;

  caliptra_imem_ldr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (accept),
    .push_data   (push_entry),
    .pop         (wr_issue),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .level       (fifo_level),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  always_comb begin
    hazard_hit = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == LDR_ADDR_W'(core_addr))) hazard_hit = 1'b1;
    end
    hazard_hit = hazard_hit & core_cs;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ext_ready = 1'b0;
    load_busy = 1'b0;
    load_done = 1'b0;
    start_ok  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        load_done = (state == DONE);
        if (load_start) begin
          start_ok  = 1'b1;
          state_nxt = (load_words == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        load_busy = 1'b1;
        ext_ready = ~fifo_full;
        if (ext_valid && !fifo_full && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        load_busy = 1'b1;
        if (fifo_empty) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Session word counter and sticky read-after-write hazard flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt    <= '0;
      word_target <= '0;
      raw_hazard  <= 1'b0;
    end else begin
      if (start_ok) begin
        word_cnt    <= '0;
        word_target <= load_words;
      end else if (accept) begin
        word_cnt    <= word_cnt + CNT_W'(1);
      end
      if (hazard_hit) raw_hazard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_caliptra_imem_load_arbiter.sv
// Directed and randomized checks of the ICCM load arbiter against a queue-based session model.
module tb_caliptra_imem_load_arbiter;

  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_words;
  logic          ext_valid;
  logic          ext_ready;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          core_cs;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_rdata;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          load_busy;
  logic          load_done;
  logic [2:0]    fifo_level;
  logic          raw_hazard;

  always #5 clk = ~clk;

  caliptra_imem_load_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_words (load_words),
    .ext_valid  (ext_valid),
    .ext_ready  (ext_ready),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .core_cs    (core_cs),
    .core_addr  (core_addr),
    .core_rdata (core_rdata),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .fifo_level (fifo_level),
    .raw_hazard (raw_hazard)
  );

  // SRAM with one-cycle read latency.
  logic [DW-1:0] sram_mem [8192];
  always @(posedge clk) begin
    if (sram_cs === 1'b1) begin
      if (sram_we === 1'b1) sram_mem[sram_addr] <= sram_wdata;
      else                  sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Reference model: committed memory image, pending-write queue, session bookkeeping.
  logic [DW-1:0] ref_mem [8192];
  beat_t         mq[$];
  beat_t         beats[$];
  bit            m_active, m_done, m_hazard, m_rd_vld;
  int            m_acc, m_target;
  logic [DW-1:0] m_rd;
  bit            vld_en;
  int            errors = 0;
  int            checks = 0;
  int            wcount = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive loader beat, compare mid-cycle, advance model, return at next negedge.
  task automatic tick();
    bit exp_ready, wr, acc, hit, was_active;
    ext_valid = vld_en && (beats.size() > 0);
    if (beats.size() > 0) begin
      ext_addr  = beats[0].addr;
      ext_wdata = beats[0].data;
    end
    #2;
    exp_ready = m_active && (m_acc < m_target) && (mq.size() < DEPTH);
    wr        = !core_cs && (mq.size() > 0);
    chk("ext_ready", 64'(ext_ready), 64'(exp_ready));
    chk("load_busy", 64'(load_busy), 64'(m_active));
    chk("load_done", 64'(load_done), 64'(m_done));
    chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
    chk("raw_hazard", 64'(raw_hazard), 64'(m_hazard));
    chk("sram_cs", 64'(sram_cs), 64'(core_cs | wr));
    chk("sram_we", 64'(sram_we), 64'(wr));
    if (core_cs) chk("sram_addr_rd", 64'(sram_addr), 64'(core_addr));
    else if (wr) begin
      chk("sram_addr_wr", 64'(sram_addr), 64'(mq[0].addr));
      chk("sram_wdata", sram_wdata, mq[0].data);
    end
    if (m_rd_vld) chk("core_rdata", core_rdata, m_rd);
    if (sram_we === 1'b1) wcount++;

    acc        = exp_ready && ext_valid;
    was_active = m_active;
    m_rd_vld   = core_cs;
    if (core_cs) m_rd = ref_mem[core_addr];
    if (rst) begin
      mq.delete();
      m_active = 0;
      m_done   = 0;
      m_hazard = 0;
      m_acc    = 0;
    end else begin
      hit = 0;
      foreach (mq[i]) if (core_cs && (mq[i].addr == core_addr)) hit = 1;
      if (hit) m_hazard = 1;
      if (m_active && (m_acc == m_target) && (mq.size() == 0)) begin
        m_active = 0;
        m_done   = 1;
      end
      if (wr) begin
        ref_mem[mq[0].addr] = mq[0].data;
        void'(mq.pop_front());
      end
      if (acc) begin
        mq.push_back(beats[0]);
        void'(beats.pop_front());
        m_acc++;
      end
      if (!was_active && load_start) begin
        if (load_words == '0) m_done = 1;
        else begin
          m_active = 1;
          m_done   = 0;
          m_acc    = 0;
          m_target = int'(load_words);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic start(input int words);
    load_words = 14'(words);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic add_beat(input logic [AW-1:0] a);
    beat_t b;
    b.addr = a;
    b.data = {$urandom, $urandom};
    beats.push_back(b);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !m_done; i++) tick();
    chk(tag, 64'(load_done), 64'd1);
  endtask

  task automatic rst_cycle();
    rst       = 1'b1;
    core_cs   = 1'b1;
    core_addr = 13'h1fff;
    beats.delete();
    tick();
    rst     = 1'b0;
    core_cs = 1'b0;
  endtask

  initial begin
    beat_t s1[$];
    for (int i = 0; i < 8192; i++) begin
      sram_mem[i] = {32'hc0de_0000 | 32'(i), ~32'(i)};
      ref_mem[i]  = {32'hc0de_0000 | 32'(i), ~32'(i)};
    end
    rst = 1'b1; load_start = 1'b0; load_words = '0; ext_valid = 1'b0;
    ext_addr = '0; ext_wdata = '0; core_cs = 1'b1; core_addr = 13'h1fff; vld_en = 1'b0;
    m_active = 0; m_done = 0; m_hazard = 0; m_rd_vld = 0; m_acc = 0; m_target = 0; m_rd = '0;
    repeat (2) @(negedge clk);
    tick();
    rst = 1'b0; core_cs = 1'b0;

    // Four back-to-back beats with an idle core, then read them back.
    vld_en = 1'b1;
    for (int i = 0; i < 4; i++) add_beat(13'h100 + 13'(i));
    s1 = beats;
    wcount = 0;
    start(4);
    wait_done("s1_done", 20);
    chk("s1_writes", 64'(wcount), 64'd4);
    for (int i = 0; i < 4; i++) begin
      core_cs = 1'b1; core_addr = s1[i].addr;
      tick();
      chk("s1_readback", core_rdata, s1[i].data);
    end
    core_cs = 1'b0;

    // Core busy throughout: buffer fills, loader stalls, then drains when core goes idle.
    wcount = 0; core_cs = 1'b1; core_addr = 13'h1000;
    for (int i = 0; i < 6; i++) add_beat(13'h200 + 13'(i));
    start(6);
    repeat (6) tick();
    chk("s2_level_full", 64'(fifo_level), 64'd4);
    chk("s2_ready_low", 64'(ext_ready), 64'd0);
    chk("s2_no_write", 64'(wcount), 64'd0);
    core_cs = 1'b0;
    wait_done("s2_done", 30);
    chk("s2_writes", 64'(wcount), 64'd6);

    // Alternating fetches during a load.
    wcount = 0;
    for (int i = 0; i < 6; i++) add_beat(13'h300 + 13'(i));
    start(6);
    for (int i = 0; i < 30 && !m_done; i++) begin
      core_cs = i[0]; core_addr = 13'h1800 + 13'(i);
      tick();
    end
    core_cs = 1'b0;
    wait_done("s3_done", 20);
    chk("s3_writes", 64'(wcount), 64'd6);

    // Read of an address still waiting in the buffer.
    rst_cycle();
    chk("s4_hazard_clear", 64'(raw_hazard), 64'd0);
    core_cs = 1'b1; core_addr = 13'h0200;
    add_beat(13'h010); add_beat(13'h011);
    start(2);
    repeat (3) tick();
    chk("s4_pre_hazard", 64'(raw_hazard), 64'd0);
    core_addr = 13'h010;
    tick();
    chk("s4_hazard_set", 64'(raw_hazard), 64'd1);
    core_cs = 1'b0;
    wait_done("s4_done", 20);
    chk("s4_hazard_sticky", 64'(raw_hazard), 64'd1);

    // Zero-length session completes immediately and never opens the loader.
    rst_cycle();
    add_beat(13'h020);
    start(0);
    chk("s5_done", 64'(load_done), 64'd1);
    chk("s5_busy", 64'(load_busy), 64'd0);
    repeat (4) tick();
    chk("s5_ready", 64'(ext_ready), 64'd0);
    beats.delete();

    // Reset with three writes buffered discards them.
    core_cs = 1'b1; core_addr = 13'h1fff;
    for (int i = 0; i < 3; i++) add_beat(13'h040 + 13'(i));
    start(8);
    repeat (4) tick();
    chk("s6_level3", 64'(fifo_level), 64'd3);
    beats.delete();
    rst = 1'b1;
    tick();
    chk("s6_level_rst", 64'(fifo_level), 64'd0);
    chk("s6_busy_rst", 64'(load_busy), 64'd0);
    rst = 1'b0; core_cs = 1'b0; wcount = 0;
    repeat (4) tick();
    chk("s6_no_write", 64'(wcount), 64'd0);

    // Randomized traffic over a small address window to provoke hazards and duplicates.
    for (int n = 0; n < 500; n++) begin
      if (beats.size() < 2) add_beat(13'h010 + 13'($urandom_range(0, 7)));
      vld_en     = ($urandom_range(0, 3) != 0);
      core_cs    = ($urandom_range(0, 2) == 0);
      core_addr  = 13'h010 + 13'($urandom_range(0, 7));
      load_words = 14'($urandom_range(0, 6));
      load_start = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      if (rst) begin
        core_cs = 1'b1;
        beats.delete();
      end
      tick();
    end
    rst = 1'b0; load_start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
